// File: rtl/fpga_steady_state_pkg.sv
// Shared constants and FSM state types for the steady-state AXI4-Lite register slave.
package fpga_steady_state_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/fpga_steady_state_regbank.sv
// Register array with byte-strobe merge, per-register commit pulses and read mux.
module fpga_steady_state_regbank
    import fpga_steady_state_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned IDX_W     = 2,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    output logic                   wr_hit,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [31:0]            rd_data,
    output logic                   rd_hit,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [NUM_REGS-1:0]    reg_wr_pulse
);

    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q;
    logic [NUM_REGS-1:0] pulse_d;

    // Index compare per register keeps out-of-range indices from aliasing into the array.
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        wr_hit  = 1'b0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_hit = 1'b1;
                if (wr_en) begin
                    pulse_d[i] = 1'b1;
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_hit  = 1'b1;
                rd_data = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs_q[i];
        end
    end

    assign reg_wr_pulse = pulse_q;

endmodule

// File: rtl/fpga_steady_state_axil_regs.sv
// AXI4-Lite slave front end: independent write and read handshake FSMs over the register bank.
module fpga_steady_state_axil_regs
    import fpga_steady_state_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS           = 4,
    parameter logic [31:0] RESET_VAL          = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]            reg_out,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    wr_state_t  wr_state_q, wr_state_d;
    logic       aw_held_q, aw_held_d;
    logic       w_held_q, w_held_d;
    logic [IDX_W-1:0] awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;

    rd_state_t  rd_state_q, rd_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        wr_commit;
    logic        wr_hit;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Commit one cycle after both halves are held, so AW and W may arrive in any order.
    assign wr_commit = (wr_state_q == WR_IDLE) && aw_held_q && w_held_q;

    fpga_steady_state_regbank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .clk          (ACLK),
        .rst          (ARESET),
        .wr_en        (wr_commit),
        .wr_idx       (awidx_q),
        .wr_data      (wdata_q),
        .wr_strb      (wstrb_q),
        .wr_hit       (wr_hit),
        .rd_idx       (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_commit) begin
                    wr_state_d = WR_RESP;
                    bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    if (S_AXI_AWVALID && !aw_held_q) begin
                        aw_held_d = 1'b1;
                        awidx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    end
                    if (S_AXI_WVALID && !w_held_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read data is sampled at the AR edge, so a same-edge write commit is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = rd_data;
                    rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = (wr_state_q == WR_IDLE) && !aw_held_q;
        S_AXI_WREADY  = (wr_state_q == WR_IDLE) && !w_held_q;
        S_AXI_BVALID  = (wr_state_q == WR_RESP);
        S_AXI_BRESP   = bresp_q;
        S_AXI_ARREADY = (rd_state_q == RD_IDLE);
        S_AXI_RVALID  = (rd_state_q == RD_DATA);
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
    end

endmodule

// File: tb/tb_fpga_steady_state_axil_regs.sv
// Directed bench: driver pushes expected B/R responses into queues, a negedge monitor pops and compares.
module tb_fpga_steady_state_axil_regs;

    localparam int AW = 5;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [AW-1:0] AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    int b_count = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];

    always #5 ACLK = ~ACLK;

    fpga_steady_state_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (4),
        .RESET_VAL          (32'h0)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                b_count++;
                if (exp_b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_b: got bresp %0h expected no response", BRESP);
                end else begin
                    check("bresp", 128'(BRESP), 128'(exp_b_q.pop_front()));
                end
            end
            if (RVALID && RREADY) begin
                if (exp_r_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_r: got rdata %0h expected no response", RDATA);
                end else begin
                    logic [33:0] e;
                    e = exp_r_q.pop_front();
                    check("rdata", 128'(RDATA), 128'(e[31:0]));
                    check("rresp", 128'(RRESP), 128'(e[33:32]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (reg_wr_pulse[i]) pulse_cnt[i]++;
            end
        end
    end

    task automatic send_aw(input logic [AW-1:0] a);
        AWADDR  = a;
        AWVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (AWREADY) begin
                @(posedge ACLK); #1;
                AWVALID = 1'b0;
                return;
            end
        end
        AWVALID = 1'b0;
        timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        WDATA  = d;
        WSTRB  = s;
        WVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (WREADY) begin
                @(posedge ACLK); #1;
                WVALID = 1'b0;
                return;
            end
        end
        WVALID = 1'b0;
        timeout("w_handshake");
    endtask

    task automatic send_aw_w(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_take;
        logic w_take;
        AWADDR = a; AWVALID = 1'b1;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            aw_take = AWVALID && AWREADY;
            w_take  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_take) AWVALID = 1'b0;
            if (w_take)  WVALID  = 1'b0;
            if (!AWVALID && !WVALID) return;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        timeout("aw_w_handshake");
    endtask

    task automatic wait_b();
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (BVALID && BREADY) begin
                @(posedge ACLK); #1;
                return;
            end
        end
        timeout("b_handshake");
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
        exp_b_q.push_back(resp);
        send_aw_w(a, d, s);
        wait_b();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] resp);
        int n;
        exp_r_q.push_back({resp, d});
        ARADDR  = a;
        ARVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (ARREADY) break;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        if (n == 50) timeout("ar_handshake");
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (RVALID && RREADY) begin
                @(posedge ACLK); #1;
                return;
            end
        end
        timeout("r_handshake");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 128'(AWREADY), 128'(1));
        check({tag, "_wready"},  128'(WREADY),  128'(1));
        check({tag, "_arready"}, 128'(ARREADY), 128'(1));
        check({tag, "_bvalid"},  128'(BVALID),  128'(0));
        check({tag, "_rvalid"},  128'(RVALID),  128'(0));
        check({tag, "_bresp"},   128'(BRESP),   128'(0));
        check({tag, "_rresp"},   128'(RRESP),   128'(0));
        check({tag, "_rdata"},   128'(RDATA),   128'(0));
        check({tag, "_reg_out"}, reg_out,       128'(0));
        check({tag, "_pulse"},   128'(reg_wr_pulse), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] snap;
        int           pc_snap [4];
        int           b0;

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b1;
        ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("reset");
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // 1: full-word writes to every register, then read back
        for (int i = 0; i < 4; i++) begin
            do_write(AW'(4 * i), 32'(i + 1), 4'hF, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            check("t1_pulse_count", 128'(pulse_cnt[i]), 128'(1));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(4 * i), 32'(i + 1), 2'b00);
        end
        check("t1_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

        // 2: byte-strobe merge
        do_write(5'h00, 32'h0000_0001, 4'hF, 2'b00);
        do_write(5'h00, 32'hAABB_CCDD, 4'b0101, 2'b00);
        do_read(5'h00, 32'h00BB_00DD, 2'b00);
        check("t2_pulse_count", 128'(pulse_cnt[0]), 128'(3));

        // 3: W arrives alone, AW three cycles later
        b0 = b_count;
        send_w(32'h0000_0055, 4'hF);
        repeat (3) begin
            @(negedge ACLK);
            check("t3_wready_low", 128'(WREADY), 128'(0));
            check("t3_no_bvalid", 128'(BVALID), 128'(0));
        end
        @(posedge ACLK); #1;
        exp_b_q.push_back(2'b00);
        send_aw(5'h08);
        wait_b();
        repeat (3) @(negedge ACLK);
        check("t3_b_count", 128'(b_count - b0), 128'(1));
        check("t3_reg2", 128'(reg_out[95:64]), 128'h55);
        @(posedge ACLK); #1;
        do_read(5'h08, 32'h0000_0055, 2'b00);

        // 4: out-of-range index
        snap = reg_out;
        for (int i = 0; i < 4; i++) pc_snap[i] = pulse_cnt[i];
        do_write(5'h10, 32'hDEAD_BEEF, 4'hF, 2'b10);
        do_read(5'h10, 32'h0, 2'b10);
        do_read(5'h1F, 32'h0, 2'b10);
        check("t4_regs_unchanged", reg_out, snap);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_pulse", 128'(pulse_cnt[i]), 128'(pc_snap[i]));
        end

        // 5: B held off while a read proceeds
        BREADY = 1'b0;
        exp_b_q.push_back(2'b00);
        send_aw_w(5'h0C, 32'h0000_0033, 4'hF);
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge ACLK);
                if (BVALID) break;
            end
            if (n == 20) timeout("t5_bvalid");
            @(posedge ACLK); #1;
        end
        do_read(5'h04, 32'h0000_0002, 2'b00);
        repeat (5) begin
            @(negedge ACLK);
            check("t5_bvalid_held", 128'(BVALID), 128'(1));
            check("t5_awready_low", 128'(AWREADY), 128'(0));
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        wait_b();
        check("t5_reg3", 128'(reg_out[127:96]), 128'h33);

        // 6: reset between AW capture and W
        send_aw(5'h00);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("t6_reset");
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        b0 = b_count;
        send_w(32'h0000_0077, 4'hF);
        repeat (5) @(negedge ACLK);
        check("t6_no_b", 128'(b_count - b0), 128'(0));
        check("t6_regs_clear", reg_out, 128'(0));
        @(posedge ACLK); #1;
        exp_b_q.push_back(2'b00);
        send_aw(5'h04);
        wait_b();
        check("t6_reg1", 128'(reg_out[63:32]), 128'h77);
        do_write(5'h08, 32'h0000_0099, 4'hF, 2'b00);
        do_read(5'h08, 32'h0000_0099, 2'b00);
        do_read(5'h04, 32'h0000_0077, 2'b00);

        repeat (3) @(negedge ACLK);
        check("b_queue_drained", 128'(exp_b_q.size()), 128'(0));
        check("r_queue_drained", 128'(exp_r_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
